// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the PS/2 key event controller.
package ps2_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_SKIP
  } ps2_state_t;

  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] SC_E1      = 8'hE1;
  localparam logic [7:0] SC_ERR0    = 8'h00;
  localparam logic [7:0] SC_ERRF    = 8'hFF;
  localparam int         PAUSE_TAIL = 7;
  localparam logic [7:0] LED_RESET  = 8'h3C;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; the head reads as zero while empty.
module ps2_event_fifo
  import ps2_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK50MHZ,
  input  logic                          RST_N,
  input  logic                          push,
  input  ps2_event_t                    wdata,
  input  logic                          pop,
  output ps2_event_t                    rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ps2_event_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK50MHZ) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Turns the PS/2 scancode byte stream into buffered make/break key events.
// Optional prefix timeout enabled by defining PS2_PREFIX_TIMEOUT_EN.
module ps2_key_event_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK50MHZ,
  input  logic       RST_N,
  input  logic [7:0] scancode,
  input  logic       scan_ready,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] led,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ps2_state_t       state, state_nxt;
  logic [2:0]       skip_cnt, skip_nxt;
  logic             push;
  ps2_event_t       push_ev;
  logic             pop;
  ps2_event_t       head_ev;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push_ok;
  logic             drop;
  logic             timeout_hit;

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N)                                           to_cnt <= '0;
    else if (scan_ready || state == ST_IDLE || timeout_hit) to_cnt <= '0;
    else                                                  to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    push      = 1'b0;
    push_ev   = '0;
    if (scan_ready) begin
      case (state)
        ST_IDLE: begin
          if (scancode == SC_E0) begin
            state_nxt = ST_GOT_E0;
          end else if (scancode == SC_F0) begin
            state_nxt = ST_GOT_F0;
          end else if (scancode == SC_E1) begin
            state_nxt = ST_SKIP;
            skip_nxt  = 3'(PAUSE_TAIL);
          end else if (scancode != SC_ERR0 && scancode != SC_ERRF) begin
            push    = 1'b1;
            push_ev = '{code: scancode, ext: 1'b0, brk: 1'b0};
          end
        end
        ST_GOT_E0: begin
          if (scancode == SC_F0) begin
            state_nxt = ST_GOT_E0F0;
          end else if (scancode != SC_E0) begin
            push      = 1'b1;
            push_ev   = '{code: scancode, ext: 1'b1, brk: 1'b0};
            state_nxt = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          push      = 1'b1;
          push_ev   = '{code: scancode, ext: 1'b0, brk: 1'b1};
          state_nxt = ST_IDLE;
        end
        ST_GOT_E0F0: begin
          push      = 1'b1;
          push_ev   = '{code: scancode, ext: 1'b1, brk: 1'b1};
          state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          // Pause has no break code; the whole 8-byte sequence yields one event.
          if (skip_cnt == 3'd1) begin
            push      = 1'b1;
            push_ev   = '{code: SC_E1, ext: 1'b0, brk: 1'b0};
            state_nxt = ST_IDLE;
            skip_nxt  = '0;
          end else begin
            skip_nxt = skip_cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          skip_nxt  = '0;
        end
      endcase
    end else if (timeout_hit) begin
      state_nxt = ST_IDLE;
      skip_nxt  = '0;
    end
  end

  assign pop      = ev_ready && !fifo_empty;
  assign drop     = push && (fifo_count == CNT_W'(FIFO_DEPTH)) && !pop;
  assign push_ok  = push && (!fifo_full || pop);

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK50MHZ (CLK50MHZ),
    .RST_N    (RST_N),
    .push     (push),
    .wdata    (push_ev),
    .pop      (pop),
    .rdata    (head_ev),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_break = head_ev.brk;

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      led      <= LED_RESET;
      overflow <= 1'b0;
    end else begin
      if (push_ok && !push_ev.brk) led <= push_ev.code;
      if (clr_overflow)            overflow <= 1'b0;
      else if (drop)               overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed self-checking bench for ps2_key_event_ctrl.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 50000;

  logic       CLK50MHZ = 1'b0;
  logic       RST_N;
  logic [7:0] scancode;
  logic       scan_ready;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] led;
  logic       overflow;
  logic       clr_overflow;

  int checks   = 0;
  int failures = 0;

  ps2_key_event_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK50MHZ     (CLK50MHZ),
    .RST_N        (RST_N),
    .scancode     (scancode),
    .scan_ready   (scan_ready),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .led          (led),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the edge that captures the byte.
  task automatic strobe(input logic [7:0] b);
    @(posedge CLK50MHZ); #1;
    scancode   = b;
    scan_ready = 1'b1;
    @(posedge CLK50MHZ); #1;
    scan_ready = 1'b0;
  endtask

  task automatic expect_ev(input string tag, input logic [7:0] code,
                           input logic ext, input logic brk);
    chk({tag, ".valid"}, 32'(ev_valid), 32'd1);
    chk({tag, ".code"},  32'(ev_code),  32'(code));
    chk({tag, ".ext"},   32'(ev_ext),   32'(ext));
    chk({tag, ".brk"},   32'(ev_break), 32'(brk));
  endtask

  task automatic pop_one;
    ev_ready = 1'b1;
    @(posedge CLK50MHZ); #1;
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] codes [5];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    codes     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    RST_N = 1'b0; scancode = 8'h1C; scan_ready = 1'b1;
    ev_ready = 1'b1; clr_overflow = 1'b0;
    repeat (3) @(posedge CLK50MHZ);
    #1;
    chk("rst.valid", 32'(ev_valid), 32'd0);
    chk("rst.code",  32'(ev_code),  32'd0);
    chk("rst.ext",   32'(ev_ext),   32'd0);
    chk("rst.brk",   32'(ev_break), 32'd0);
    chk("rst.ovf",   32'(overflow), 32'd0);
    chk("rst.led",   32'(led),      32'h3C);
    scan_ready = 1'b0;
    @(negedge CLK50MHZ); RST_N = 1'b1;

    strobe(8'h1C);
    expect_ev("make", 8'h1C, 1'b0, 1'b0);
    chk("make.led", 32'(led), 32'h1C);
    @(posedge CLK50MHZ); #1;
    chk("make.popped", 32'(ev_valid), 32'd0);

    strobe(8'hF0); strobe(8'h1C);
    expect_ev("brk", 8'h1C, 1'b0, 1'b1);
    chk("brk.led", 32'(led), 32'h1C);
    pop_one();

    strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
    expect_ev("extbrk", 8'h75, 1'b1, 1'b1);
    chk("extbrk.led", 32'(led), 32'h1C);
    pop_one();

    strobe(8'hE0); strobe(8'hE0); strobe(8'h6B);
    expect_ev("ext", 8'h6B, 1'b1, 1'b0);
    chk("ext.led", 32'(led), 32'h6B);
    pop_one();

    strobe(8'h00); strobe(8'hFF);
    chk("err.valid", 32'(ev_valid), 32'd0);
    chk("err.led",   32'(led),      32'h6B);

    for (int i = 0; i < 7; i++) strobe(pause_seq[i]);
    chk("pause.early", 32'(ev_valid), 32'd0);
    strobe(pause_seq[7]);
    expect_ev("pause", 8'hE1, 1'b0, 1'b0);
    chk("pause.led", 32'(led), 32'hE1);
    pop_one();
    chk("pause.once", 32'(ev_valid), 32'd0);

    // Fill without consuming; the fifth make code must be dropped.
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(codes[i]);
    chk("ovf.set",  32'(overflow), 32'd1);
    chk("ovf.led",  32'(led),      32'h44);
    chk("ovf.head", 32'(ev_code),  32'h11);
    clr_overflow = 1'b1;
    @(posedge CLK50MHZ); #1;
    clr_overflow = 1'b0;
    chk("ovf.clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(ev_code), 32'(codes[i]));
      pop_one();
    end
    chk("drain.empty", 32'(ev_valid), 32'd0);

    // Full FIFO with push and pop in the same cycle: both take effect.
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'h21 + 8'(i));
    @(posedge CLK50MHZ); #1;
    scancode = 8'h25; scan_ready = 1'b1; ev_ready = 1'b1;
    @(posedge CLK50MHZ); #1;
    scan_ready = 1'b0; ev_ready = 1'b0;
    chk("pp.ovf",  32'(overflow), 32'd0);
    chk("pp.led",  32'(led),      32'h25);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp.drain%0d", i), 32'(ev_code), 32'(8'h22 + 8'(i)));
      pop_one();
    end
    chk("pp.empty", 32'(ev_valid), 32'd0);

    // Reset mid-sequence discards the pending F0.
    strobe(8'h5A);
    strobe(8'hF0);
    #3 RST_N = 1'b0;
    #2;
    chk("mid.led",   32'(led),      32'h3C);
    chk("mid.valid", 32'(ev_valid), 32'd0);
    @(negedge CLK50MHZ); RST_N = 1'b1;
    strobe(8'h1C);
    expect_ev("mid.next", 8'h1C, 1'b0, 1'b0);
    pop_one();

`ifdef PS2_PREFIX_TIMEOUT_EN
    strobe(8'hE0);
    repeat (TO) @(posedge CLK50MHZ);
    #1;
    strobe(8'h1C);
    expect_ev("tmo", 8'h1C, 1'b0, 1'b0);
    pop_one();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequences the raw PS/2 scancode byte stream (scancode/scan_ready from the keyboard receiver) into whole key events: make/break and extended flags plus a key code.
- Buffers events in a small FIFO and presents them to one consumer with a valid/ready handshake.
- Drives the board LEDs with the code of the last key pressed.
- Sits between the PS/2 receiver and the application logic, replacing direct byte-to-LED latching.

Parameters:
- FIFO_DEPTH, 4, number of event entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000, clock cycles allowed between prefix bytes; 1 ms at 50 MHz; only used with PREFIX_TIMEOUT_EN.

Ports:
- CLK50MHZ  input  1  system clock, 50 MHz.
- RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
- scancode  input  8  received byte; valid only when scan_ready=1.
- scan_ready  input  1  single-cycle strobe, one byte per strobe.
- ev_valid  output  1  FIFO head holds an event.
- ev_ready  input  1  consumer accepts the head; pop when ev_valid & ev_ready.
- ev_code  output  8  head key code.
- ev_ext  output  1  head event had an E0 prefix.
- ev_break  output  1  head event is a release (F0 prefix).
- led  output  8  last make-event code.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- clr_overflow  input  1  clears overflow; has priority over a same-cycle set.

Behaviour:
- Reset (RST_N=0, async) sets:
  - FSM=IDLE, FIFO empty, ev_valid=0, ev_code/ev_ext/ev_break=0, overflow=0, led=8'h3C, skip counter=0.
  - scan_ready is ignored while in reset.
  - Reset in the middle of a sequence discards the partial sequence.
- FSM advances only on cycles with scan_ready=1. States: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP.
- IDLE:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - E1 -> SKIP, skip counter=7.
  - 00 or FF (receiver error codes) -> discarded, stay in IDLE.
  - Any other byte -> push {code, ext=0, brk=0}, stay in IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stay in GOT_E0.
  - Any other byte -> push {code, 1, 0} -> IDLE.
- GOT_F0: any byte -> push {code, 0, 1} -> IDLE.
- GOT_E0F0: any byte -> push {code, 1, 1} -> IDLE.
- SKIP (Pause sequence, 7 further bytes):
  - Each byte decrements the counter.
  - The byte that arrives with counter=1 pushes {8'hE1, 0, 0} -> IDLE.
  - Byte values are not checked.
- Latency: final byte strobed at cycle N -> entry written at edge N+1. If the FIFO was empty, ev_valid=1 and head fields are valid in cycle N+1 (first-word-fall-through; head read combinationally from the storage array).
- FIFO:
  - Push when full and no pop in the same cycle -> event dropped, overflow<=1, led unchanged.
  - Push and pop in the same cycle when full -> both take effect, count unchanged.
  - Push and pop in the same cycle when empty -> push only; the pop is impossible because ev_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. Count is held in a separate log2(FIFO_DEPTH)+1-bit register.
- led: updated to code on every accepted make push (brk=0), including the E1 Pause event. Break events and dropped events leave led unchanged.

Optional Feature:
- Macro PS2_PREFIX_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while the FSM is in GOT_E0, GOT_F0, GOT_E0F0 or SKIP, and restarts on every scan_ready.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, the FSM returns to IDLE with no event pushed.
  - A byte arriving in the same cycle as the timeout is processed as if it came in the old state; the byte wins.
- Undefined: no counter; the FSM waits indefinitely in a prefix state.

Decomposition:
- Package ps2_ctrl_pkg:
  - FSM state enum.
  - Constants SC_E0=8'hE0, SC_F0=8'hF0, SC_E1=8'hE1, SC_ERR0=8'h00, SC_ERRF=8'hFF, PAUSE_TAIL=7, LED_RESET=8'h3C.
  - Packed event type {code[7:0], ext, brk} (10 bits).
- Sub-module ps2_event_fifo: parameterised synchronous FIFO with async active-low reset and full/empty/count outputs. The top level holds the FSM, skip/timeout counters, led and overflow.

Test Plan:
- Reset, then strobe 1C, ev_ready=1 -> one cycle later ev_valid=1, code=1C, ext=0, brk=0; led=1C after the edge.
- Strobe F0, 1C -> event {1C, 0, 1}; led stays 1C.
- Strobe E0, F0, 75 -> event {75, 1, 1}. Strobe E0, E0, 6B -> event {6B, 1, 0}.
- Strobe E1, 14, 77, E1, F0, 14, F0, 77 -> exactly one event {E1, 0, 0}, emitted on the 8th byte; led=E1.
- ev_ready=0, 5 make codes with FIFO_DEPTH=4 -> first 4 retained in order, 5th dropped, overflow=1. Pulse clr_overflow -> overflow=0. Drain yields the 4 codes in order.
- With PS2_PREFIX_TIMEOUT_EN: strobe E0, wait TIMEOUT_CYCLES, strobe 1C -> event {1C, 0, 0}. Assert RST_N low mid-sequence after F0 -> outputs return to reset values; next byte 1C gives {1C, 0, 0}.
